// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM among CORE_NUM cores.
// Registered memory port; load data is routed back to the issuing core after MEM_LAT.
module mem_arbiter #(
  parameter int CORE_NUM = 16,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prog_loading,
  input  logic [CORE_NUM-1:0]        req,
  input  logic [CORE_NUM-1:0]        req_we,
  input  logic [CORE_NUM*ADDR_W-1:0] req_addr,
  input  logic [CORE_NUM*DATA_W-1:0] req_wdata,
  output logic [CORE_NUM-1:0]        gnt,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [CORE_NUM-1:0]        rsp_valid,
  output logic [DATA_W-1:0]          rsp_data
);

  localparam int IDX_W = $clog2(CORE_NUM);

  logic [CORE_NUM-1:0] gnt_q, gnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CORE_NUM-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [MEM_LAT-1:0]  pipe_vld_q, pipe_vld_d;
  logic [IDX_W-1:0]    pipe_idx_q [MEM_LAT];
  logic [IDX_W-1:0]    pipe_idx_d [MEM_LAT];

  logic [CORE_NUM-1:0] eligible;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    gnt_idx;

  // The current grant holder is masked so a request left high through its own
  // grant cycle cannot win twice in a row.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [IDX_W-1:0] cand;
    eligible  = req & ~gnt_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < CORE_NUM; k++) begin
      cand = rr_ptr_q + IDX_W'(k);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (gnt_q[i]) gnt_idx = IDX_W'(i);
    end
  end

  always_comb begin
    gnt_d       = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rr_ptr_d    = rr_ptr_q;
    if (!prog_loading && win_found) begin
      gnt_d       = CORE_NUM'(1) << win_idx;
      mem_en_d    = 1'b1;
      mem_we_d    = req_we[win_idx];
      mem_addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
      mem_wdata_d = req_wdata[win_idx*DATA_W +: DATA_W];
      rr_ptr_d    = win_idx + IDX_W'(1);
    end

    // Return pipeline: one stage per cycle of memory latency.
    pipe_vld_d[0] = mem_en_q & ~mem_we_q;
    pipe_idx_d[0] = gnt_idx;
    for (int s = 1; s < MEM_LAT; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_idx_d[s] = pipe_idx_q[s-1];
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pipe_vld_q[MEM_LAT-1]) begin
      rsp_valid_d = CORE_NUM'(1) << pipe_idx_q[MEM_LAT-1];
      rsp_data_d  = mem_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rr_ptr_q    <= '0;
      pipe_vld_q  <= '0;
    end else begin
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rr_ptr_q    <= rr_ptr_d;
      pipe_vld_q  <= pipe_vld_d;
    end
  end

  // NOTE: pipeline core indices are payload qualified by pipe_vld_q, so they
  // carry no reset; only the valid bits must clear.
  always_ff @(posedge clk) begin
    pipe_idx_q <= pipe_idx_d;
  end

  assign gnt       = gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

  localparam int CN = 16;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int ML = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            prog_loading;
  logic [CN-1:0]   req;
  logic [CN-1:0]   req_we;
  logic [CN*AW-1:0] req_addr;
  logic [CN*DW-1:0] req_wdata;
  logic [CN-1:0]   gnt;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [CN-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;

  mem_arbiter #(.CORE_NUM(CN), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML)) dut (
    .clk(clk), .reset(reset), .prog_loading(prog_loading),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with ML-cycle read latency; unwritten words hold init_val.
  logic [DW-1:0]       ram [1<<AW];
  bit   [(1<<AW)-1:0]  ram_wr;
  logic [DW-1:0]       rd1, rd2;

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return (a == 10'h005) ? 16'hBEEF : (DW'(a) ^ 16'hA5A5);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end else if (mem_en) begin
      rd1 <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  typedef struct {
    logic [CN-1:0] gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            load_rsp;
  } gexp_t;

  typedef struct {
    logic [CN-1:0] core;
    logic [DW-1:0] data;
  } rexp_t;

  gexp_t gnt_exp[$];
  rexp_t rsp_exp[$];
  int    lat_exp[$];
  int    gnt_cyc[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    rsp_seen = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  gexp_t ge;
  rexp_t re;
  always @(negedge clk) begin
    cyc++;
    if (mem_en) begin
      gnt_cyc.push_back(cyc);
      if (gnt_exp.size() == 0) begin
        check("unexpected_grant", 64'(mem_en), 64'd0);
      end else begin
        ge = gnt_exp.pop_front();
        check("gnt", 64'(gnt), 64'(ge.gnt));
        check("mem_we", 64'(mem_we), 64'(ge.we));
        check("mem_addr", 64'(mem_addr), 64'(ge.addr));
        if (ge.we) check("mem_wdata", 64'(mem_wdata), 64'(ge.wdata));
        if (ge.load_rsp) lat_exp.push_back(cyc + ML + 1);
      end
    end else if (gnt != '0) begin
      check("gnt_without_mem_en", 64'(mem_en), 64'd1);
    end
    if (rsp_valid != '0) begin
      rsp_seen++;
      if (rsp_exp.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        re = rsp_exp.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(re.core));
        check("rsp_data", 64'(rsp_data), 64'(re.data));
        if (lat_exp.size() != 0) check("rsp_latency_cycle", 64'(cyc), 64'(lat_exp.pop_front()));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    req = req & ~gnt;
  endtask

  task automatic drive(int c, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    req[c]                 = 1'b1;
    req_we[c]              = we;
    req_addr[c*AW +: AW]   = a;
    req_wdata[c*DW +: DW]  = d;
  endtask

  task automatic expect_gnt(int c, bit we, logic [AW-1:0] a, logic [DW-1:0] d, bit rsp);
    gexp_t e;
    e.gnt = CN'(1) << c;
    e.we = we;
    e.addr = a;
    e.wdata = d;
    e.load_rsp = rsp;
    gnt_exp.push_back(e);
  endtask

  task automatic expect_rsp(int c, logic [DW-1:0] d);
    rexp_t r;
    r.core = CN'(1) << c;
    r.data = d;
    rsp_exp.push_back(r);
  endtask

  task automatic drain(string name, int budget);
    for (int i = 0; i < budget && (gnt_exp.size() != 0 || rsp_exp.size() != 0); i++) tick();
    tick();
    check({name, "_pending_grants"}, 64'(gnt_exp.size()), 64'd0);
    check({name, "_pending_rsps"}, 64'(rsp_exp.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(string name);
    check({name, "_gnt"}, 64'(gnt), 64'd0);
    check({name, "_mem_en"}, 64'(mem_en), 64'd0);
    check({name, "_mem_we"}, 64'(mem_we), 64'd0);
    check({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({name, "_rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen0;
    reset = 1'b1; prog_loading = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;

    // Single load: core 3 reads 0x005 (holds 0xBEEF).
    drive(3, 1'b0, 10'h005, 16'h0);
    expect_gnt(3, 1'b0, 10'h005, 16'h0, 1'b1);
    expect_rsp(3, 16'hBEEF);
    tick();
    check("t1_gnt_next_cycle", 64'(gnt), 64'h0008);
    check("t1_mem_addr", 64'(mem_addr), 64'h005);
    drain("t1", 10);

    // Round-robin: core 5 wins, then 3 and 7 together -> 7 before 3.
    drive(5, 1'b1, 10'h010, 16'h5555);
    expect_gnt(5, 1'b1, 10'h010, 16'h5555, 1'b0);
    tick();
    drive(3, 1'b1, 10'h011, 16'h3333);
    drive(7, 1'b1, 10'h012, 16'h7777);
    expect_gnt(7, 1'b1, 10'h012, 16'h7777, 1'b0);
    expect_gnt(3, 1'b1, 10'h011, 16'h3333, 1'b0);
    tick();
    check("t2_first_gnt", 64'(gnt), 64'h0080);
    tick();
    check("t2_second_gnt", 64'(gnt), 64'h0008);
    drain("t2", 10);

    // Store then load to the same address on consecutive cycles.
    drive(2, 1'b1, 10'h3FF, 16'h1234);
    expect_gnt(2, 1'b1, 10'h3FF, 16'h1234, 1'b0);
    tick();
    check("t3_store_we", 64'(mem_we), 64'd1);
    drive(9, 1'b0, 10'h3FF, 16'h0);
    expect_gnt(9, 1'b0, 10'h3FF, 16'h0, 1'b1);
    expect_rsp(9, 16'h1234);
    tick();
    check("t3_load_we", 64'(mem_we), 64'd0);
    check("t3_load_gnt", 64'(gnt), 64'h0200);
    drain("t3", 10);

    // Full contention from reset: grants 0..15 back to back.
    reset = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset2");
    reset = 1'b0;
    for (int i = 0; i < CN; i++) begin
      drive(i, 1'b0, 10'h020 + 10'(i), 16'h0);
      expect_gnt(i, 1'b0, 10'h020 + 10'(i), 16'h0, 1'b1);
      expect_rsp(i, (16'h0020 + 16'(i)) ^ 16'hA5A5);
    end
    base = gnt_cyc.size();
    drain("t4", 40);
    if (gnt_cyc.size() >= base + CN)
      check("t4_grant_span", 64'(gnt_cyc[base+CN-1] - gnt_cyc[base]), 64'(CN - 1));
    else
      check("t4_grant_count", 64'(gnt_cyc.size() - base), 64'(CN));

    // Freeze: load on core 6, then prog_loading for 4 edges while 12 and 1 request.
    drive(6, 1'b0, 10'h030, 16'h0);
    expect_gnt(6, 1'b0, 10'h030, 16'h0, 1'b1);
    expect_rsp(6, 16'hA595);
    tick();
    seen0 = rsp_seen;
    prog_loading = 1'b1;
    drive(12, 1'b0, 10'h040, 16'h0);
    drive(1, 1'b0, 10'h041, 16'h0);
    expect_gnt(12, 1'b0, 10'h040, 16'h0, 1'b1);
    expect_gnt(1, 1'b0, 10'h041, 16'h0, 1'b1);
    expect_rsp(12, 16'hA5E5);
    expect_rsp(1, 16'hA5E4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_frozen_gnt", 64'(gnt), 64'd0);
    end
    check("t5_rsp_during_freeze", 64'(rsp_seen - seen0), 64'd1);
    prog_loading = 1'b0;
    tick();
    check("t5_resume_gnt", 64'(gnt), 64'h1000);
    tick();
    check("t5_second_gnt", 64'(gnt), 64'h0002);
    drain("t5", 10);

    // Reset in the cycle after a load's mem_en drops the response.
    drive(4, 1'b0, 10'h050, 16'h0);
    expect_gnt(4, 1'b0, 10'h050, 16'h0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_outputs_zero("t6_reset");
    reset = 1'b0;
    seen0 = rsp_seen;
    repeat (8) tick();
    check("t6_no_rsp_after_reset", 64'(rsp_seen - seen0), 64'd0);
    check("t6_pending_grants", 64'(gnt_exp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
